// File: rtl/wallace_multiplier.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH Wallace-tree multiplier: AND-array partial
// products, layered 3:2 / 2:2 compression, final carry-propagate add, one output register.
module wallace_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] c
);

  localparam int PW = 2 * WIDTH;
  localparam int IB = $clog2(WIDTH) + 1;
  localparam int CW = 2 ** IB;

  // Number of Wallace layers needed to bring every column down to two bits.
  function automatic int layer_count(input int w);
    int h  [512];
    int nh [512];
    int tallest, layers, f, r, cin;
    layers = 0;
    for (int k = 0; k < 512; k++) begin
      h[k]  = (k < 2*w-1) ? ((k < w) ? k + 1 : 2*w - 1 - k) : 0;
      nh[k] = 0;
    end
    tallest = w;
    while (tallest > 2) begin
      cin     = 0;
      tallest = 0;
      for (int k = 0; k < 2*w; k++) begin
        f     = h[k] / 3;
        r     = h[k] % 3;
        nh[k] = f + ((r != 0) ? 1 : 0) + cin;
        cin   = f + ((r == 2) ? 1 : 0);
        if (nh[k] > tallest) tallest = nh[k];
      end
      for (int k = 0; k < 2*w; k++) h[k] = nh[k];
      layers++;
    end
    return layers;
  endfunction

  localparam int LAYERS = layer_count(WIDTH);

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  logic [PW-1:0] sum_row;
  logic [PW-1:0] carry_row;
  logic [PW-1:0] prod_p1;
  logic          vld_p1;

  // Stage 0: partial products and reduction tree; each column is a bit bag with a fill count.
  always_comb begin : tree
    logic [CW-1:0] cur [PW];
    logic [CW-1:0] nxt [PW];
    logic [IB-1:0] h   [PW];
    logic [IB-1:0] nh  [PW];
    logic [1:0]    sc;
    sc = '0;
    for (int k = 0; k < PW; k++) begin
      cur[k] = '0;
      nxt[k] = '0;
      h[k]   = '0;
      nh[k]  = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cur[i+j][h[i+j]] = a[j] & b[i];
        h[i+j]           = h[i+j] + IB'(1);
      end
    end
    for (int l = 0; l < LAYERS; l++) begin
      for (int k = 0; k < PW; k++) begin
        nxt[k] = '0;
        nh[k]  = '0;
      end
      for (int k = 0; k < PW; k++) begin
        for (int g = 0; g < WIDTH; g += 3) begin
          if (g + 2 < int'(h[k]))
            sc = full_add(cur[k][g], cur[k][g+1], cur[k][g+2]);
          else if (g + 1 < int'(h[k]))
            sc = half_add(cur[k][g], cur[k][g+1]);
          else
            sc = {1'b0, cur[k][g]};
          if (g < int'(h[k])) begin
            nxt[k][nh[k]] = sc[0];
            nh[k]         = nh[k] + IB'(1);
            // The top column never produces a carry for unsigned operands.
            if ((k + 1 < PW) && (g + 1 < int'(h[k]))) begin
              nxt[k+1][nh[k+1]] = sc[1];
              nh[k+1]           = nh[k+1] + IB'(1);
            end
          end
        end
      end
      cur = nxt;
      h   = nh;
    end
    for (int k = 0; k < PW; k++) begin
      sum_row[k]   = cur[k][0];
      carry_row[k] = cur[k][1];
    end
  end

  // Stage 1: carry-propagate add into the product register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      prod_p1 <= sum_row + carry_row;
      vld_p1  <= in_valid;
    end
  end

  assign c         = prod_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_wallace_multiplier.sv
// Self-checking bench for wallace_multiplier: fixed corner cases, a back-to-back
// stream and randomized operands against a plain 64-bit arithmetic model.
module tb_wallace_multiplier;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a        = '0;
  logic [31:0] b        = '0;
  logic        out_valid;
  logic [63:0] c;

  int total = 0;
  int bad   = 0;

  wallace_multiplier #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .c        (c)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] golden(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    return p;
  endfunction

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    a        = 32'hFFFF_FFFF;
    b        = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (c !== 64'd0) begin
      bad++;
      $display("FAIL reset_c got=%h want=%h", c, 64'd0);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_vld got=%b want=0", out_valid);
    end
    @(negedge clock);
    reset_n  = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_corners();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [63:0] te [5];
    ta = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    tb = '{32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0001_0000};
    te = '{64'h0, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
           64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      a        = ta[i];
      b        = tb[i];
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if (c !== te[i]) begin
        bad++;
        $display("FAIL corner%0d a=%h b=%h got=%h want=%h", i, ta[i], tb[i], c, te[i]);
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL corner%0d_vld got=%b want=1", i, out_valid);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [256];
    logic [31:0] vb [256];
    logic [63:0] ve [256];
    int errs;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      ve[i] = golden(va[i], vb[i]);
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      a        = va[i];
      b        = vb[i];
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if (c !== ve[i]) begin
        bad++;
        errs++;
        $display("FAIL b2b%0d got=%h want=%h", i, c, ve[i]);
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        errs++;
        $display("FAIL b2b%0d_vld got=%b want=1", i, out_valid);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      errs++;
      $display("FAIL b2b_vld_drop got=%b want=0", out_valid);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL b2b_errors got=%0d want=0", errs);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic        v;
    for (int i = 0; i < 10000; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 8 == 0) x = x & 32'h0000_FFFF;
      if (i % 8 == 1) y = y | 32'hFFFF_0000;
      v = 1'($urandom_range(0, 1));
      @(negedge clock);
      a        = x;
      b        = y;
      in_valid = v;
      @(posedge clock);
      #1;
      total++;
      if (c !== golden(x, y)) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h got=%h want=%h", i, x, y, c, golden(x, y));
      end
      total++;
      if (out_valid !== v) begin
        bad++;
        $display("FAIL rand%0d_vld got=%b want=%b", i, out_valid, v);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] x, y;
    x = $urandom | 32'h1;
    y = $urandom | 32'h1;
    @(negedge clock);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (c !== golden(x, y)) begin
      bad++;
      $display("FAIL pre_arst got=%h want=%h", c, golden(x, y));
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (c !== 64'd0) begin
      bad++;
      $display("FAIL arst_c got=%h want=%h", c, 64'd0);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL arst_vld got=%b want=0", out_valid);
    end
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    total++;
    if (c !== 64'd0) begin
      bad++;
      $display("FAIL arst_hold got=%h want=%h", c, 64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (c !== 64'hFFFF_FFFE_0000_0001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_arst got=%h/%b want=%h/1", c, out_valid, 64'hFFFF_FFFE_0000_0001);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
